uart_cmd_fifo_bridge: RTL
=========================

// Module: uart_cmd_fifo_bridge
// PURPOSE
//   Buffered command bridge between the UART byte interface (uart_controller) and the stopwatch/watch core.
//   Received bytes enter a parametrised RX FIFO. A decoder FSM turns them into one-cycle command pulses and optionally echoes each byte.
//   Echoed bytes go through a TX FIFO, drained with a proper tx_start/tx_busy handshake.
//   Replaces the direct rx->tx FIFO loopback. Adds command decode, error/overflow status and occupancy counts.
// PARAMETERS
//   DATA_W        8   byte width on rx_data/tx_data; must be >= 8; commands compare against zero-extended ASCII
//   RX_DEPTH_LOG2 3   RX FIFO depth = 2**RX_DEPTH_LOG2 entries
//   TX_DEPTH_LOG2 3   TX FIFO depth = 2**TX_DEPTH_LOG2 entries
//   ECHO_EN       1   1: every popped RX byte is pushed to the TX FIFO; 0: TX path unused (tx_start never asserts)
//   CASE_FOLD     1   1: lower-case letters 'a'..'z' are decoded like upper case; 0: upper case only
// PORTS
//   clk          in   1                 system clock
//   reset        in   1                 asynchronous, active-high reset
//   rx_done      in   1                 one-cycle strobe: rx_data valid
//   rx_data      in   DATA_W            received byte
//   tx_busy      in   1                 UART transmitter busy
//   clr_err      in   1                 clears rx_overflow and err_cnt
//   tx_start     out  1                 one-cycle start strobe to UART TX
//   tx_data      out  DATA_W            byte to send; held stable from tx_start until tx_busy falls
//   cmd_clear    out  1                 pulse on 'C'
//   cmd_runstop  out  1                 pulse on 'R'
//   cmd_up       out  1                 pulse on 'U'
//   cmd_down     out  1                 pulse on 'D'
//   cmd_mode     out  1                 pulse on 'M'
//   cmd_setting  out  1                 pulse on 'S'
//   rx_count     out  RX_DEPTH_LOG2+1   RX FIFO occupancy
//   tx_count     out  TX_DEPTH_LOG2+1   TX FIFO occupancy
//   rx_overflow  out  1                 sticky: rx_done arrived while RX FIFO full (byte dropped)
//   err_cnt      out  8                 saturating count of unrecognised bytes (stops at 255)
// BEHAVIOUR
//   - Reset: all outputs 0, both FIFOs empty, both FSMs idle. Reset mid-transfer aborts immediately; in-flight byte and FIFO contents are lost.
//   - FIFOs: registered pointers with wrap at 2**LOG2 and an extra MSB to tell full from empty.
//     Push while full is dropped, even with a simultaneous pop. Pop while empty is ignored.
//   - RX push: rx_done=1 and not full -> write at that edge. If full -> byte dropped, rx_overflow<=1.
//     If set and clr_err coincide, set wins.
//   - Decoder FSM, states D_IDLE, D_DECODE, D_ECHO_WAIT:
//     D_IDLE: RX not empty -> pop, latch byte, go to D_DECODE.
//     D_DECODE (exactly 1 cycle): assert the matching cmd_* pulse, or increment err_cnt on no match.
//       If ECHO_EN and TX not full -> push byte, go to D_IDLE.
//       If ECHO_EN and TX full -> go to D_ECHO_WAIT.
//       If !ECHO_EN -> go to D_IDLE.
//     D_ECHO_WAIT: no pulses; push byte when TX not full, then go to D_IDLE.
//   - Latency: rx_done in cycle 0 (RX empty, decoder idle) -> cmd pulse high in cycle 2 and echo push in cycle 2. At most one cmd pulse per cycle.
//   - TX FSM, states T_IDLE, T_WAIT_HI, T_WAIT_LO:
//     T_IDLE: TX not empty and tx_busy=0 -> pop, register tx_data, tx_start=1 in the next cycle, go to T_WAIT_HI.
//     T_WAIT_HI: wait for tx_busy=1, then go to T_WAIT_LO.
//     T_WAIT_LO: wait for tx_busy=0, then go to T_IDLE.
//     Echo pushed in cycle 2 -> tx_start high in cycle 4.
//   - Decoded bytes are sent in arrival order, with no loss unless the RX FIFO overflows.
//   - clr_err=1: rx_overflow<=0 and err_cnt<=0 at the next edge, unless a new event occurs in the same cycle.
//   - Unknown bytes (e.g. CR/LF) are still echoed.
// TESTING
//   1. Reset with RX FIFO holding 3 bytes -> all outputs 0, rx_count=0, tx_count=0; no tx_start afterwards.
//   2. rx_done with 'R' (0x52) in cycle 0 -> cmd_runstop=1 in cycle 2 only; tx_start in cycle 4 with tx_data=0x52.
//   3. CASE_FOLD=1, 'u' -> cmd_up pulse. CASE_FOLD=0, 'u' -> no pulse, err_cnt=1, byte still echoed.
//   4. tx_busy held 1; send 'C','U','D','M','S', then 8 more bytes -> decode stalls in D_ECHO_WAIT once TX is full.
//      Further bytes fill RX; the 9th excess byte sets rx_overflow. After tx_busy is released, bytes transmit in order.
//   5. tx_busy model rises 1 cycle after tx_start, falls 20 cycles later -> next tx_start no earlier than 1 cycle after the fall.
//   6. 256 unknown bytes -> err_cnt=255 (saturated). clr_err plus a new unknown byte in the same cycle -> err_cnt stays nonzero.
//      clr_err alone -> err_cnt=0 and rx_overflow=0.

Source files
------------

// File: rtl/uart_cmd_fifo_bridge.sv
// UART command bridge: RX FIFO -> command decoder with optional echo -> TX FIFO
// drained through a tx_start / tx_busy handshake.
module uart_cmd_fifo_bridge #(
  parameter int DATA_W        = 8,
  parameter int RX_DEPTH_LOG2 = 3,
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int ECHO_EN       = 1,
  parameter int CASE_FOLD     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     tx_busy,
  input  logic                     clr_err,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     cmd_clear,
  output logic                     cmd_runstop,
  output logic                     cmd_up,
  output logic                     cmd_down,
  output logic                     cmd_mode,
  output logic                     cmd_setting,
  output logic [RX_DEPTH_LOG2:0]   rx_count,
  output logic [TX_DEPTH_LOG2:0]   tx_count,
  output logic                     rx_overflow,
  output logic [7:0]               err_cnt
);

  localparam int RXN = 1 << RX_DEPTH_LOG2;
  localparam int TXN = 1 << TX_DEPTH_LOG2;

  typedef enum logic [1:0] {D_IDLE, D_DECODE, D_ECHO_WAIT} dec_state_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT_HI, T_WAIT_LO} tx_state_t;

  // One-hot {setting, mode, down, up, runstop, clear}; ASCII compared zero-extended.
  function automatic logic [5:0] f_decode(input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] c;
    c = b;
    if (CASE_FOLD != 0 && b >= DATA_W'(8'h61) && b <= DATA_W'(8'h7A))
      c = b - DATA_W'(8'h20);
    f_decode = {c == DATA_W'(8'h53), c == DATA_W'(8'h4D), c == DATA_W'(8'h44),
                c == DATA_W'(8'h55), c == DATA_W'(8'h52), c == DATA_W'(8'h43)};
  endfunction

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0]      r_rx_mem [RXN];
  logic [RX_DEPTH_LOG2:0] r_rx_wr, r_rx_rd;
  logic                   w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic [DATA_W-1:0]      w_rx_head;
  logic                   r_rx_ovf;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr == {~r_rx_rd[RX_DEPTH_LOG2], r_rx_rd[RX_DEPTH_LOG2-1:0]});
  assign w_rx_push  = rx_done && !w_rx_full;
  assign w_rx_head  = r_rx_mem[r_rx_rd[RX_DEPTH_LOG2-1:0]];
  assign rx_count   = r_rx_wr - r_rx_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[RX_DEPTH_LOG2-1:0]] <= rx_data;
  end

  // A new drop in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_rx_ovf <= 1'b0;
    else if (rx_done && w_rx_full) r_rx_ovf <= 1'b1;
    else if (clr_err)              r_rx_ovf <= 1'b0;
  end
  assign rx_overflow = r_rx_ovf;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0]      r_tx_mem [TXN];
  logic [TX_DEPTH_LOG2:0] r_tx_wr, r_tx_rd;
  logic                   w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [DATA_W-1:0]      w_tx_head;

  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr == {~r_tx_rd[TX_DEPTH_LOG2], r_tx_rd[TX_DEPTH_LOG2-1:0]});
  assign w_tx_head  = r_tx_mem[r_tx_rd[TX_DEPTH_LOG2-1:0]];
  assign tx_count   = r_tx_wr - r_tx_rd;

  // ---------------- Decoder FSM ----------------
  dec_state_t        r_dstate;
  logic [DATA_W-1:0] r_byte;
  logic [5:0]        r_cmd;
  logic [7:0]        r_err;

  assign w_rx_pop  = (r_dstate == D_IDLE) && !w_rx_empty;
  assign w_tx_push = (ECHO_EN != 0) && !w_tx_full &&
                     (r_dstate == D_DECODE || r_dstate == D_ECHO_WAIT);

  // r_cmd is loaded at the pop so the pulse lines up exactly with D_DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dstate <= D_IDLE;
      r_byte   <= '0;
      r_cmd    <= '0;
      r_err    <= '0;
    end else begin
      r_cmd <= '0;
      case (r_dstate)
        D_IDLE: if (!w_rx_empty) begin
          r_byte   <= w_rx_head;
          r_cmd    <= f_decode(w_rx_head);
          r_dstate <= D_DECODE;
        end
        D_DECODE: begin
          if (ECHO_EN == 0 || !w_tx_full) r_dstate <= D_IDLE;
          else                            r_dstate <= D_ECHO_WAIT;
        end
        D_ECHO_WAIT: if (!w_tx_full) r_dstate <= D_IDLE;
        default: r_dstate <= D_IDLE;
      endcase
      if (r_dstate == D_DECODE && r_cmd == '0) begin
        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
      end else if (clr_err) begin
        r_err <= '0;
      end
    end
  end

  assign {cmd_setting, cmd_mode, cmd_down, cmd_up, cmd_runstop, cmd_clear} = r_cmd;
  assign err_cnt = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TX_DEPTH_LOG2-1:0]] <= r_byte;
  end

  // ---------------- TX FSM ----------------
  tx_state_t         r_tstate;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;

  assign w_tx_pop = (r_tstate == T_IDLE) && !w_tx_empty && !tx_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tstate   <= T_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_tstate)
        T_IDLE: if (!w_tx_empty && !tx_busy) begin
          r_tx_data  <= w_tx_head;
          r_tx_start <= 1'b1;
          r_tstate   <= T_WAIT_HI;
        end
        T_WAIT_HI: if (tx_busy)  r_tstate <= T_WAIT_LO;
        T_WAIT_LO: if (!tx_busy) r_tstate <= T_IDLE;
        default: r_tstate <= T_IDLE;
      endcase
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule
